// File: rtl/layer_out_serializer_pkg.sv
// Shared defaults and shift-FSM encodings for the layer output serializer.
package layer_out_serializer_pkg;

    localparam int NUM_NEURONS_DEF = 30;
    localparam int DATA_WIDTH_DEF  = 16;

    typedef logic [0:0] state_t;

    localparam state_t STATE_IDLE  = 1'b0;
    localparam state_t STATE_SHIFT = 1'b1;

endpackage

// File: rtl/layer_out_serializer_collector.sv
// Collect bank: one register and one mask bit per upstream neuron.
// Exposes the post-capture bank so a frame completing this cycle can transfer immediately.
module neuron_out_collector
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] inData_i,
    input  logic [NUM_NEURONS-1:0]            inValid_i,
    input  logic                              clear_i,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] dataNext_o,
    output logic [NUM_NEURONS-1:0]            mask_o,
    output logic                              frameReady_o,
    output logic                              overflow_o
);

    logic [NUM_NEURONS*DATA_WIDTH-1:0] bank_q, bank_d;
    logic [NUM_NEURONS-1:0]            mask_q, mask_d;
    logic [NUM_NEURONS-1:0]            accept;
    logic                              overflow_q, overflow_d;

    // A strobe on a neuron whose word is already held is dropped and flagged, never overwritten.
    always_comb begin
        accept = inValid_i & ~mask_q;
        bank_d = bank_q;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (accept[i]) begin
                bank_d[i*DATA_WIDTH +: DATA_WIDTH] = inData_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        mask_d     = clear_i ? '0 : (mask_q | inValid_i);
        overflow_d = overflow_q | (|(inValid_i & mask_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q     <= '0;
            mask_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            mask_q     <= mask_d;
            overflow_q <= overflow_d;
        end
    end

    assign dataNext_o   = bank_d;
    assign mask_o       = mask_q;
    assign frameReady_o = &(mask_q | inValid_i);
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/layer_out_serializer.sv
// Gathers one word per upstream neuron, then streams them neuron 0 first onto the next layer's input bus.
// Output registers are loaded from next-state values so word 0 appears the cycle after the frame completes.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_NEURONS-1:0]            in_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overflow
);

    localparam int                IDX_W    = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [NUM_NEURONS*DATA_WIDTH-1:0] collectNext;
    logic [NUM_NEURONS-1:0]            collectMask;
    logic                              frameReady;
    logic                              transfer;

    logic [NUM_NEURONS*DATA_WIDTH-1:0] shiftBank_q, shiftBank_d;
    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [DATA_WIDTH-1:0]             outData_q, outData_d;
    logic                              outValid_q, outValid_d;
    logic                              outLast_q, outLast_d;

    neuron_out_collector #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_collector (
        .clk          (clk),
        .rst          (rst),
        .inData_i     (in_data),
        .inValid_i    (in_valid),
        .clear_i      (transfer),
        .dataNext_o   (collectNext),
        .mask_o       (collectMask),
        .frameReady_o (frameReady),
        .overflow_o   (overflow)
    );

    // idx_q is the index of the word currently on out_data; a full collect bank waits for the last word.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shiftBank_d = shiftBank_q;
        transfer    = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (frameReady) begin
                    transfer    = 1'b1;
                    shiftBank_d = collectNext;
                    idx_d       = '0;
                    state_d     = STATE_SHIFT;
                end
            end
            default: begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (frameReady) begin
                        transfer    = 1'b1;
                        shiftBank_d = collectNext;
                    end else begin
                        state_d = STATE_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
        outValid_d = (state_d == STATE_SHIFT);
        outData_d  = outValid_d ? shiftBank_d[idx_d*DATA_WIDTH +: DATA_WIDTH] : '0;
        outLast_d  = outValid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_IDLE;
            idx_q       <= '0;
            shiftBank_q <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shiftBank_q <= shiftBank_d;
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            outLast_q   <= outLast_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign busy      = (state_q == STATE_SHIFT) | (|collectMask);

endmodule
